// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the writeback/memory consumer.
// The master side produces ALU results and consumes the head; the slave side is the buffer.
interface alu_result_buffer_if #(
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_res;
    logic              in_zero;
    logic              in_overflow;
    logic [2:0]        in_op;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_res;
    logic              out_zero;
    logic              out_ovf;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_res, in_zero, in_overflow, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_res, in_zero, in_overflow, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_ovf, out_tag
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO between the ALU and writeback: stores result, flags and tag, and keeps a sticky
// record of the first add overflow accepted since the last clear.
module alu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    alu_result_buffer_if.slave         bus,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_sticky,
    output logic [TAG_W-1:0]           ovf_tag
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + 2 + TAG_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0]       OP_ADD   = 3'b010;

    // Overflow only means something for an add; other ops' flag is dropped at capture.
    function automatic logic qualify_ovf(input logic ovf, input logic [2:0] op);
        return ovf && (op == OP_ADD);
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [TAG_W-1:0] ovf_tag_q, ovf_tag_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               push_ovf;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head_entry;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        push     = bus.in_valid && !full;
        pop      = !empty && bus.out_ready;
        push_ovf = push && qualify_ovf(bus.in_overflow, bus.in_op);
        entry_in = {bus.in_res, bus.in_zero, qualify_ovf(bus.in_overflow, bus.in_op), bus.in_tag};
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_tag_d    = ovf_tag_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A coinciding clear and overflow push leaves the new overflow recorded.
        if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
            ovf_tag_d    = '0;
        end
        if (push_ovf && (!ovf_sticky_q || ovf_clr)) begin
            ovf_sticky_d = 1'b1;
            ovf_tag_d    = bus.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
            ovf_tag_q    <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_tag_q    <= ovf_tag_d;
        end
    end

    // Storage is not reset; the write is gated by push, which reset suppresses via rstn.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[tail_q] <= entry_in;
        end
    end

    always_comb begin
        head_entry    = empty ? '0 : mem[head_q];
        bus.in_ready  = !full;
        bus.out_valid = !empty;
        bus.out_res   = head_entry[ENTRY_W-1 -: 32];
        bus.out_zero  = head_entry[TAG_W+1];
        bus.out_ovf   = head_entry[TAG_W];
        bus.out_tag   = head_entry[TAG_W-1:0];
        count         = count_q;
        ovf_sticky    = ovf_sticky_q;
        ovf_tag       = ovf_tag_q;
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and randomized bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0]      res;
        logic             zero;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    ovf_clr;
    logic [$clog2(DEPTH):0]  count;
    logic                    ovf_sticky;
    logic [TAG_W-1:0]        ovf_tag;

    alu_result_buffer_if #(.TAG_W(TAG_W)) bus ();

    alu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .ovf_clr    (ovf_clr),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_tag    (ovf_tag)
    );

    always #5 clk = ~clk;

    ent_t             mq[$];
    logic             m_sticky;
    logic [TAG_W-1:0] m_tag;
    int               vectors = 0;
    int               miscompares = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = '{res: '0, zero: 1'b0, ovf: 1'b0, tag: '0};
        if (mq.size() > 0) h = mq[0];
        check("count",      64'(count),         64'(mq.size()));
        check("in_ready",   64'(bus.in_ready),  64'(mq.size() < DEPTH));
        check("out_valid",  64'(bus.out_valid), 64'(mq.size() > 0));
        check("out_res",    64'(bus.out_res),   64'(h.res));
        check("out_zero",   64'(bus.out_zero),  64'(h.zero));
        check("out_ovf",    64'(bus.out_ovf),   64'(h.ovf));
        check("out_tag",    64'(bus.out_tag),   64'(h.tag));
        check("ovf_sticky", 64'(ovf_sticky),    64'(m_sticky));
        check("ovf_tag",    64'(ovf_tag),       64'(m_tag));
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic ovf,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic ordy, input logic clr);
        bus.in_valid    = v;
        bus.in_res      = res;
        bus.in_zero     = (res == 32'd0);
        bus.in_overflow = ovf;
        bus.in_op       = op;
        bus.in_tag      = tag;
        bus.out_ready   = ordy;
        ovf_clr         = clr;
    endtask

    // One clock: the model decides from its own pre-edge state, then both are compared after the edge.
    task automatic tick();
        bit   do_push, do_pop, is_add_ovf, was_sticky;
        ent_t e;
        do_push    = bus.in_valid && (mq.size() < DEPTH);
        do_pop     = (mq.size() > 0) && bus.out_ready;
        is_add_ovf = bus.in_overflow && (bus.in_op == 3'b010);
        e = '{res: bus.in_res, zero: bus.in_zero, ovf: is_add_ovf, tag: bus.in_tag};
        @(posedge clk);
        if (!rstn) begin
            mq.delete();
            m_sticky = 1'b0;
            m_tag    = '0;
        end else begin
            was_sticky = m_sticky;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            if (ovf_clr) begin
                m_sticky = 1'b0;
                m_tag    = '0;
            end
            if (do_push && is_add_ovf && (!was_sticky || ovf_clr)) begin
                m_sticky = 1'b1;
                m_tag    = e.tag;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        mq.delete();
        m_sticky = 1'b0;
        m_tag    = '0;

        // Reset held two cycles while in_valid is asserted.
        rstn = 1'b0;
        drive(1'b1, 32'h1234, 1'b1, 3'b010, 5'd1, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_sticky", 64'(ovf_sticky), 64'd0);
        check("rst_out_res", 64'(bus.out_res), 64'd0);
        rstn = 1'b1;

        // Single pass with 1-cycle latency.
        drive(1'b1, 32'h5, 1'b0, 3'b010, 5'd3, 1'b1, 1'b0);
        tick();
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_res", 64'(bus.out_res), 64'd5);
        check("single_tag", 64'(bus.out_tag), 64'd3);
        check("single_zero", 64'(bus.out_zero), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        tick();
        check("single_drained", 64'(count), 64'd0);

        // Fill, drop the third push, then drain in order.
        drive(1'b1, 32'hA, 1'b0, 3'b000, 5'd10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 3'b000, 5'd11, 1'b0, 1'b0);
        tick();
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_count", 64'(count), 64'd2);
        drive(1'b1, 32'hC, 1'b0, 3'b000, 5'd12, 1'b0, 1'b0);
        tick();
        check("full_drop_head", 64'(bus.out_res), 64'hA);
        // Push while full and popping the same cycle is still ignored.
        drive(1'b1, 32'hC, 1'b0, 3'b000, 5'd12, 1'b1, 1'b0);
        tick();
        check("drain_b", 64'(bus.out_res), 64'hB);
        check("drain_count", 64'(count), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        tick();
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Steady push+pop at occupancy one, across pointer wrap.
        drive(1'b1, 32'd1, 1'b0, 3'b001, 5'd1, 1'b0, 1'b0);
        tick();
        for (int k = 2; k <= 8; k++) begin
            drive(1'b1, 32'(k), 1'b0, 3'b001, 5'(k), 1'b1, 1'b0);
            tick();
            check("stream_count", 64'(count), 64'd1);
            check("stream_res", 64'(bus.out_res), 64'(k));
        end
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        tick();

        // Sticky overflow: first tag wins, non-add overflow is discarded.
        drive(1'b1, 32'h8000_0000, 1'b1, 3'b010, 5'd7, 1'b0, 1'b0);
        tick();
        check("ovf_out", 64'(bus.out_ovf), 64'd1);
        check("ovf_sticky1", 64'(ovf_sticky), 64'd1);
        check("ovf_tag7", 64'(ovf_tag), 64'd7);
        drive(1'b1, 32'h8000_0001, 1'b1, 3'b010, 5'd9, 1'b0, 1'b0);
        tick();
        check("ovf_tag_kept", 64'(ovf_tag), 64'd7);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h7, 1'b1, 3'b110, 5'd1, 1'b0, 1'b0);
        tick();
        check("ovf_nonadd", 64'(bus.out_ovf), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        tick();

        // Clear coinciding with an overflow push: set wins.
        drive(1'b1, 32'h9, 1'b1, 3'b010, 5'd4, 1'b1, 1'b1);
        tick();
        check("clr_set_sticky", 64'(ovf_sticky), 64'd1);
        check("clr_set_tag", 64'(ovf_tag), 64'd4);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1);
        tick();
        check("clr_sticky", 64'(ovf_sticky), 64'd0);
        check("clr_tag", 64'(ovf_tag), 64'd0);

        // Reset mid-operation with a full buffer and sticky set.
        drive(1'b1, 32'h11, 1'b1, 3'b010, 5'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0, 3'b010, 5'd3, 1'b0, 1'b0);
        tick();
        rstn = 1'b0;
        tick();
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_sticky", 64'(ovf_sticky), 64'd0);
        rstn = 1'b1;

        // Randomized traffic including occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            rstn = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 2) != 0), $urandom(), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) bus.in_op = 3'b010;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
